// File: rtl/weight_pkg.sv
// weight_pkg: kernel geometry and loader state encoding shared by the weight bank, loader and conv datapath.
package weight_pkg;
  localparam int KERNEL_TAPS = 25;
  localparam int W_WIDTH = 8;
  localparam int ADDR_WIDTH = 5;
  localparam int SUM_WIDTH = W_WIDTH + 5;
  localparam int CNT_WIDTH = ADDR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] TAPS_CNT = CNT_WIDTH'(KERNEL_TAPS);
  localparam logic [CNT_WIDTH-1:0] LAST_TAP = CNT_WIDTH'(KERNEL_TAPS - 1);
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, HOLD = 2'd2} state_t;
endpackage

// File: rtl/weight_loader.sv
// weight_loader: streams 25 signed weights into the kernel bank, one addressed write per tap; WEIGHT_CHKSUM_EN adds o_w_sum.
module weight_loader
  import weight_pkg::*;
(
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic                         i_clear,
  input  logic signed [W_WIDTH-1:0]    i_s_data,
  input  logic                         i_s_valid,
  output logic                         o_s_ready,
  output logic signed [W_WIDTH-1:0]    o_w,
  output logic        [ADDR_WIDTH-1:0] o_addr,
  output logic                         o_wr_en,
  output logic                         o_valid,
  output logic                         o_busy,
  output logic                         o_loaded,
  output logic                         o_done
`ifdef WEIGHT_CHKSUM_EN
  ,
  output logic signed [SUM_WIDTH-1:0]  o_w_sum
`endif
);
  state_t state;
  logic [CNT_WIDTH-1:0] cnt;
  logic accept;
  assign o_s_ready = (state == LOAD) && (cnt < TAPS_CNT);
  assign accept = i_s_valid && o_s_ready;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt <= '0;
      o_w <= '0;
      o_addr <= '0;
      o_wr_en <= 1'b0;
      o_valid <= 1'b0;
      o_busy <= 1'b0;
      o_loaded <= 1'b0;
      o_done <= 1'b0;
    end else if (i_clear) begin
      state <= IDLE;
      cnt <= '0;
      o_wr_en <= 1'b0;
      o_valid <= 1'b0;
      o_busy <= 1'b0;
      o_loaded <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_wr_en <= 1'b0;
      o_done <= 1'b0;
      case (state)
        IDLE: if (i_start) begin
          state <= LOAD;
          cnt <= '0;
          o_valid <= 1'b1;
          o_busy <= 1'b1;
        end
        LOAD: if (accept) begin
          o_w <= i_s_data;
          o_addr <= cnt[ADDR_WIDTH-1:0];
          o_wr_en <= 1'b1;
          cnt <= cnt + CNT_WIDTH'(1);
          if (cnt == LAST_TAP) begin
            state <= HOLD;
            o_done <= 1'b1;
            o_loaded <= 1'b1;
            o_busy <= 1'b0;
          end
        end
        HOLD: if (i_start) begin
          // o_valid stays high so the old kernel persists until overwritten
          state <= LOAD;
          cnt <= '0;
          o_busy <= 1'b1;
          o_loaded <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef WEIGHT_CHKSUM_EN
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear || (i_start && state != LOAD)) o_w_sum <= '0;
    else if (accept) o_w_sum <= o_w_sum + SUM_WIDTH'(i_s_data);
  end
`endif
endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: directed/random stimulus for weight_loader checked against a transaction-level model; WEIGHT_CHKSUM_EN checks o_w_sum.
module tb_weight_loader;
  logic i_clk = 1'b0, i_rst = 1'b1, i_start = 1'b0, i_clear = 1'b0, i_s_valid = 1'b0;
  logic signed [7:0] i_s_data = '0;
  logic o_s_ready, o_wr_en, o_valid, o_busy, o_loaded, o_done;
  logic signed [7:0] o_w;
  logic [4:0] o_addr;
`ifdef WEIGHT_CHKSUM_EN
  logic signed [12:0] o_w_sum;
`endif
  int vectors = 0, miscompares = 0;
  int m_taps, m_w, m_addr, m_sum;
  bit m_load, m_loaded, m_vld, m_wr, m_done;
  int mbank[25];
  logic signed [7:0] bank[25];

  weight_loader dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_clear(i_clear),
    .i_s_data(i_s_data), .i_s_valid(i_s_valid), .o_s_ready(o_s_ready),
    .o_w(o_w), .o_addr(o_addr), .o_wr_en(o_wr_en), .o_valid(o_valid),
    .o_busy(o_busy), .o_loaded(o_loaded), .o_done(o_done)
`ifdef WEIGHT_CHKSUM_EN
    , .o_w_sum(o_w_sum)
`endif
  );

  always #5 i_clk = ~i_clk;

  // mirror of the downstream bank, built only from the write interface
  always @(posedge i_clk) if (o_wr_en && o_addr < 5'd25) bank[o_addr] <= o_w;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic chk_outs();
    chk("wr_en", 32'(o_wr_en), 32'(m_wr));
    chk("done", 32'(o_done), 32'(m_done));
    chk("valid", 32'(o_valid), 32'(m_vld));
    chk("busy", 32'(o_busy), 32'(m_load));
    chk("loaded", 32'(o_loaded), 32'(m_loaded));
    chk("w", 32'(o_w), 32'(m_w));
    chk("addr", 32'(o_addr), 32'(m_addr));
    if (o_wr_en) chk("valid_at_wr", 32'(o_valid), 32'd1);
`ifdef WEIGHT_CHKSUM_EN
    chk("w_sum", 32'(o_w_sum), 32'(m_sum));
`endif
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_start = 1'b0; i_clear = 1'b0; i_s_valid = 1'b0;
    @(posedge i_clk); #1;
    {m_load, m_loaded, m_vld, m_wr, m_done} = '0;
    m_taps = 0; m_w = 0; m_addr = 0; m_sum = 0;
    chk("rst_ready", 32'(o_s_ready), 32'd0);
    chk_outs();
    i_rst = 1'b0;
  endtask

  task automatic step(input bit st, input bit cl, input bit sv, input logic signed [7:0] d);
    bit acc;
    i_start = st; i_clear = cl; i_s_valid = sv; i_s_data = d;
    #1;
    chk("ready", 32'(o_s_ready), 32'(m_load));
    acc = m_load && sv && !cl;
    @(posedge i_clk); #1;
    if (cl) begin
      {m_load, m_loaded, m_vld, m_wr, m_done} = '0;
      m_taps = 0; m_sum = 0;
    end else if (st && !m_load) begin
      m_load = 1; m_loaded = 0; m_vld = 1; m_wr = 0; m_done = 0; m_taps = 0; m_sum = 0;
    end else if (acc) begin
      m_wr = 1; m_w = int'(d); m_addr = m_taps; mbank[m_taps] = m_w; m_sum += m_w;
      m_taps++;
      m_done = (m_taps == 25);
      if (m_done) begin m_load = 0; m_loaded = 1; end
    end else begin
      m_wr = 0; m_done = 0;
    end
    chk_outs();
  endtask

  task automatic chk_bank();
    for (int i = 0; i < 25; i++) chk("bank", 32'(bank[i]), 32'(mbank[i]));
  endtask

  initial begin
    int n;
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'($urandom));
    step(1, 0, 0, 0);
    for (int i = 1; i <= 25; i++) step(0, 0, 1, 8'(i));
    step(0, 0, 1, 8'sd99);
    step(0, 0, 0, 0);
    chk_bank();
`ifdef WEIGHT_CHKSUM_EN
    chk("sum_325", 32'(o_w_sum), 32'd325);
`endif
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 8'($urandom));
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'($urandom));
    for (int i = 8; i < 25; i++) step(0, 0, 1, 8'($urandom));
    step(0, 0, 0, 0);
    chk_bank();
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 25; i++) step(0, 0, 1, -8'sd128);
    step(0, 0, 0, 0);
    chk_bank();
`ifdef WEIGHT_CHKSUM_EN
    chk("sum_m3200", 32'(o_w_sum), -32'sd3200);
`endif
    step(1, 0, 0, 0);
    for (int i = 0; i < 25; i++) step(i == 3, 0, 1, 8'sd5);
    step(0, 0, 0, 0);
    chk_bank();
    step(1, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 1, 8'($urandom));
    step(1, 1, 1, 8'sd77);
    step(0, 0, 1, 8'($urandom));
    step(1, 0, 0, 0);
    n = 0;
    while (!m_loaded && n < 300) begin
      step(0, 0, 1'($urandom_range(0, 1)), 8'($urandom));
      n++;
    end
    chk("reload_done", 32'(m_loaded), 32'd1);
    step(0, 0, 0, 0);
    chk_bank();
    step(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 8'($urandom));
    do_reset();
    step(0, 0, 1, 8'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
